fp_divider_scheduler: RTL and testbench
=======================================

# fp_divider_scheduler

Shares one pipelined single-precision `fp_divider` between two requesters in the encoder.
- Port A is the ACF normaliser: ACF[k] / ACF[0].
- Port B is the Levinson-Durbin stage: reflection-coefficient divides.

The block arbitrates round-robin, issues at most one divide per enabled cycle, and carries the requester ID and a user tag through the pipeline. It returns each quotient to its originating port, flagging zero denominators.

## Interface
- DIVIDER_DELAY, 14, fixed latency of `fp_divider` in enabled cycles
- TAG_WIDTH, 4, width of user tag carried with each request
- iClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iEnable  in  1  global clock enable; low freezes all state
- iA_Valid / iB_Valid  in  1  request present
- ifA_Num / ifB_Num  in  32  IEEE-754 single numerator
- ifA_Den / ifB_Den  in  32  IEEE-754 single denominator
- iA_Tag / iB_Tag  in  TAG_WIDTH  opaque tag, returned with result
- oA_Ready / oB_Ready  out  1  request accepted this cycle (combinational grant)
- oA_Valid / oB_Valid  out  1  one-cycle result strobe
- ofA_Quotient / ofB_Quotient  out  32  result
- oA_Tag / oB_Tag  out  TAG_WIDTH  tag of returned result
- oA_DivZero / oB_DivZero  out  1  denominator was ±0; quotient forced 0

## Operation
- **Acceptance.** A request is accepted on an edge where Valid & Ready & iEnable are all high.
- **Ready.** Ready is 0 whenever iEnable = 0.
- **Arbitration.**
  - Register `last_grant` (0 = A, 1 = B).
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to `last_grant` is granted.
  - `last_grant` updates on every accepted request.
  - Reset value of `last_grant` = B, so A wins the first tie.
- **Issue.** On acceptance, Num, Den and Tag are registered into the issue stage. The following are registered at the same time:
  - `zero_den` = (Den[30:0] == 0);
  - the port ID.
  - With no acceptance, the issue stage holds a bubble (`issue_valid` = 0).
- **Divide.**
  - The issue registers drive the divider.
  - Divider clk_en = iEnable.
  - A DIVIDER_DELAY-deep tracking shift register (clock-enabled by iEnable) carries {valid, port, tag, zero_den} alongside the divider.
- **Return.** When the tracking tail is valid, the result is registered into the addressed port's output regs:
  - Quotient = 0 if `zero_den`, else the divider result.
  - DivZero = `zero_den`.
  - Tag = the carried tag.
- **Output strobe.**
  - The output Valid register pulses for one enabled cycle.
  - External oX_Valid = registered valid & iEnable, so a consumer sees exactly one enabled cycle per result.
  - Quotient, Tag and DivZero hold until the next result to that port.
- **Ordering.** Results return to each port in acceptance order. There is no backpressure on outputs; requesters must always sink.

## Timing
- Throughput: one divide per enabled cycle, aggregate over both ports.
- Tie throughput: with both ports continuously valid, grants alternate A, B, A, B…
- Latency: accepted at edge k gives output Valid high in the cycle after edge k + DIVIDER_DELAY + 1, counted in enabled edges only.
- iEnable low for N cycles:
  - every register, including divider state, holds;
  - latency stretches by exactly N cycles;
  - no result is lost or duplicated.
- Reset:
  - all Valid = 0, all Ready = 0 during reset;
  - Quotients = 0, Tags = 0, DivZero = 0;
  - tracking shift register cleared, `last_grant` = B.
- Reset mid-flight: in-flight operations are discarded and no Valid is emitted for them; stale divider contents are harmless because their tracking bits are cleared.
- A request with Valid high but not granted must be held stable by the requester until Ready.

## Structure
- Shared package `encoder_fp_pkg`:
  - FP constants FP_ONE = 32'h3F800000 and FP_ZERO = 32'h00000000;
  - default DIVIDER_DELAY;
  - port ID encoding PORT_A = 0, PORT_B = 1.
- One sub-module, `fp_divider` (existing vendor IP), instantiated once. The arbiter, issue stage, tracking shift register and return demux live in this block.

## Test plan
- **Single A divide.** Inputs: A only, Num 0x3F800000, Den 0x40000000, Tag 3. Response: oA_Valid one cycle, DIVIDER_DELAY+1 cycles after accept; Quotient 0x3F000000; oA_Tag 3; oB_Valid never high.
- **Simultaneous streaming.** Stimulus: both ports valid for 8 cycles; A 0x40800000/0x40000000, B 0x41000000/0x40800000. Response:
  - grants alternate A first, with oA_Ready and oB_Ready never high together;
  - 4 results per port;
  - A = 0x40000000, B = 0x40000000, tags in order.
- **Zero denominator.** Stimulus: B request with Den 0x80000000 (−0), Tag 7. Response: oB_Valid with Quotient 0x00000000, oB_DivZero 1, Tag 7; next normal result has DivZero 0.
- **Enable gaps.** Stimulus: A streams 12 requests; iEnable toggled low 3 cycles mid-stream. Response:
  - 12 results, in order, each Valid exactly once;
  - last result arrives 3 cycles later than the no-gap run.
- **Reset mid-flight.** Stimulus: 5 requests accepted, then iReset for 1 cycle at DIVIDER_DELAY/2. Response:
  - no Valid for those 5 requests;
  - outputs 0;
  - the next request after reset returns correctly and wins the tie as A.
- **Full throughput A only.** Stimulus: 20 back-to-back requests. Response: oA_Ready constantly 1; 20 consecutive Valid cycles.

Source files
------------

// File: rtl/encoder_fp_pkg.sv
// Shared encoder floating-point definitions.
// Holds the IEEE-754 single constants, the default latency of the shared
// divider and the requester port-ID encoding carried through the pipeline.
package encoder_fp_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_ZERO = 32'h00000000;

  // Fixed latency of fp_divider, in enabled cycles.
  localparam int DIVIDER_DELAY_DEFAULT = 14;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/fp_divider_scheduler_if.sv
// Request/result bundle between the two divide requesters (ACF normaliser on
// port A, Levinson-Durbin on port B) and fp_divider_scheduler.
//
// Handshake: a request is taken on a rising edge where iX_Valid, oX_Ready and
// the global enable are all high. oX_Ready is a combinational grant that
// depends on both Valids. A requester whose Valid is high but not granted
// must keep Num/Den/Tag stable until it sees Ready. Results have no
// backpressure: oX_Valid is a one-cycle strobe the requester must sink, and
// Quotient/Tag/DivZero hold until the next result to that port.
//
// Ports (per requester X in {A, B}):
//   iX_Valid, ifX_Num, ifX_Den, iX_Tag   request side
//   oX_Ready                             grant
//   oX_Valid, ofX_Quotient, oX_Tag, oX_DivZero   result side
interface fp_divider_scheduler_if #(
  parameter int TAG_WIDTH = 4
);

  logic                 iA_Valid;
  logic [31:0]          ifA_Num;
  logic [31:0]          ifA_Den;
  logic [TAG_WIDTH-1:0] iA_Tag;
  logic                 oA_Ready;
  logic                 oA_Valid;
  logic [31:0]          ofA_Quotient;
  logic [TAG_WIDTH-1:0] oA_Tag;
  logic                 oA_DivZero;

  logic                 iB_Valid;
  logic [31:0]          ifB_Num;
  logic [31:0]          ifB_Den;
  logic [TAG_WIDTH-1:0] iB_Tag;
  logic                 oB_Ready;
  logic                 oB_Valid;
  logic [31:0]          ofB_Quotient;
  logic [TAG_WIDTH-1:0] oB_Tag;
  logic                 oB_DivZero;

  // Scheduler side.
  modport slave (
    input  iA_Valid, ifA_Num, ifA_Den, iA_Tag,
    input  iB_Valid, ifB_Num, ifB_Den, iB_Tag,
    output oA_Ready, oA_Valid, ofA_Quotient, oA_Tag, oA_DivZero,
    output oB_Ready, oB_Valid, ofB_Quotient, oB_Tag, oB_DivZero
  );

  // Requester side.
  modport master (
    output iA_Valid, ifA_Num, ifA_Den, iA_Tag,
    output iB_Valid, ifB_Num, ifB_Den, iB_Tag,
    input  oA_Ready, oA_Valid, ofA_Quotient, oA_Tag, oA_DivZero,
    input  oB_Ready, oB_Valid, ofB_Quotient, oB_Tag, oB_DivZero
  );

endinterface

// File: rtl/fp_divider.sv
// Pipelined single-precision divider with a fixed latency of DELAY enabled
// cycles. Normal operands only: a zero/denormal numerator gives a signed
// zero, a zero denominator gives infinity (the scheduler overrides that case),
// fraction bits are truncated.
// Ports:
//   clk_i     clock
//   clk_en_i  clock enable; low freezes the whole pipeline
//   a_i, b_i  numerator, denominator (IEEE-754 single)
//   q_o       quotient of the operands presented DELAY enabled edges ago
module fp_divider #(
  parameter int DELAY = 14
) (
  input  logic        clk_i,
  input  logic        clk_en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] q_o
);

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [24:0] quot;
  logic [22:0] frac;
  logic [9:0]  exp_s;
  logic [31:0] res;
  logic [31:0] pipe_q [DELAY];

  always_comb begin
    sign  = a_i[31] ^ b_i[31];
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    ma    = {1'b1, a_i[22:0]};
    mb    = {1'b1, b_i[22:0]};
    // Mantissa ratio lies in (0.5, 2), scaled by 2^24.
    quot  = 25'({ma, 24'd0} / {24'd0, mb});
    frac  = quot[24] ? quot[23:1] : quot[22:0];
    exp_s = {2'b00, ea} - {2'b00, eb} + 10'd126 + {9'd0, quot[24]};
    if (ea == 8'd0) begin
      res = {sign, 31'd0};
    end else if (eb == 8'd0 || (!exp_s[9] && exp_s >= 10'd255)) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (exp_s[9] || exp_s == 10'd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, exp_s[7:0], frac};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      pipe_q[0] <= res;
      for (int i = 1; i < DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DELAY-1];

endmodule

// File: rtl/fp_divider_scheduler.sv
// Shares one pipelined fp_divider between two requesters. Round-robin
// arbitration issues at most one divide per enabled cycle; a tracking shift
// register running alongside the divider carries {valid, port, tag, zero_den}
// so each quotient is steered back to the port that asked for it.
// Ports:
//   iClock   clock
//   iReset   synchronous, active-high reset
//   iEnable  global clock enable; low freezes all state
//   bus      requester bundle (slave side), see fp_divider_scheduler_if
module fp_divider_scheduler
  import encoder_fp_pkg::*;
#(
  parameter int DIVIDER_DELAY = DIVIDER_DELAY_DEFAULT,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  fp_divider_scheduler_if.slave   bus
);

  localparam int TAIL = DIVIDER_DELAY - 1;

  port_e                last_grant_q, last_grant_d;
  logic                 grant_a, grant_b, ready_a, ready_b, accept;

  logic                 issue_valid_q, issue_valid_d;
  port_e                issue_port_q, issue_port_d;
  logic [31:0]          issue_num_q, issue_num_d;
  logic [31:0]          issue_den_q, issue_den_d;
  logic [TAG_WIDTH-1:0] issue_tag_q, issue_tag_d;
  logic                 issue_zero_q, issue_zero_d;

  logic                 trk_valid_q [DIVIDER_DELAY];
  port_e                trk_port_q  [DIVIDER_DELAY];
  logic [TAG_WIDTH-1:0] trk_tag_q   [DIVIDER_DELAY];
  logic                 trk_zero_q  [DIVIDER_DELAY];

  logic [31:0]          div_result;

  logic                 a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [31:0]          a_quot_q, a_quot_d, b_quot_q, b_quot_d;
  logic [TAG_WIDTH-1:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic                 a_dz_q, a_dz_d, b_dz_q, b_dz_d;

  // A wins unless B is also asking and A had the previous grant.
  always_comb begin
    grant_a = bus.iA_Valid & (~bus.iB_Valid | (last_grant_q == PORT_B));
    grant_b = bus.iB_Valid & ~grant_a;
    ready_a = grant_a & iEnable & ~iReset;
    ready_b = grant_b & iEnable & ~iReset;
    accept  = ready_a | ready_b;
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    issue_valid_d = accept;
    issue_port_d  = issue_port_q;
    issue_num_d   = issue_num_q;
    issue_den_d   = issue_den_q;
    issue_tag_d   = issue_tag_q;
    issue_zero_d  = issue_zero_q;
    if (ready_b) begin
      last_grant_d = PORT_B;
      issue_port_d = PORT_B;
      issue_num_d  = bus.ifB_Num;
      issue_den_d  = bus.ifB_Den;
      issue_tag_d  = bus.iB_Tag;
      issue_zero_d = (bus.ifB_Den[30:0] == 31'd0);
    end else if (ready_a) begin
      last_grant_d = PORT_A;
      issue_port_d = PORT_A;
      issue_num_d  = bus.ifA_Num;
      issue_den_d  = bus.ifA_Den;
      issue_tag_d  = bus.iA_Tag;
      issue_zero_d = (bus.ifA_Den[30:0] == 31'd0);
    end
  end

  // Return demux: the tracking tail lines up with the divider output.
  always_comb begin
    a_valid_d = trk_valid_q[TAIL] & (trk_port_q[TAIL] == PORT_A);
    b_valid_d = trk_valid_q[TAIL] & (trk_port_q[TAIL] == PORT_B);
    a_quot_d  = a_quot_q;
    a_tag_d   = a_tag_q;
    a_dz_d    = a_dz_q;
    b_quot_d  = b_quot_q;
    b_tag_d   = b_tag_q;
    b_dz_d    = b_dz_q;
    if (a_valid_d) begin
      a_quot_d = trk_zero_q[TAIL] ? FP_ZERO : div_result;
      a_tag_d  = trk_tag_q[TAIL];
      a_dz_d   = trk_zero_q[TAIL];
    end
    if (b_valid_d) begin
      b_quot_d = trk_zero_q[TAIL] ? FP_ZERO : div_result;
      b_tag_d  = trk_tag_q[TAIL];
      b_dz_d   = trk_zero_q[TAIL];
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      last_grant_q  <= PORT_B;
      issue_valid_q <= 1'b0;
      issue_port_q  <= PORT_A;
      issue_num_q   <= FP_ZERO;
      issue_den_q   <= FP_ZERO;
      issue_tag_q   <= '0;
      issue_zero_q  <= 1'b0;
      a_valid_q     <= 1'b0;
      a_quot_q      <= FP_ZERO;
      a_tag_q       <= '0;
      a_dz_q        <= 1'b0;
      b_valid_q     <= 1'b0;
      b_quot_q      <= FP_ZERO;
      b_tag_q       <= '0;
      b_dz_q        <= 1'b0;
    end else if (iEnable) begin
      last_grant_q  <= last_grant_d;
      issue_valid_q <= issue_valid_d;
      issue_port_q  <= issue_port_d;
      issue_num_q   <= issue_num_d;
      issue_den_q   <= issue_den_d;
      issue_tag_q   <= issue_tag_d;
      issue_zero_q  <= issue_zero_d;
      a_valid_q     <= a_valid_d;
      a_quot_q      <= a_quot_d;
      a_tag_q       <= a_tag_d;
      a_dz_q        <= a_dz_d;
      b_valid_q     <= b_valid_d;
      b_quot_q      <= b_quot_d;
      b_tag_q       <= b_tag_d;
      b_dz_q        <= b_dz_d;
    end
  end

  // Clearing the tracking bits on reset is what discards in-flight divides;
  // the divider's own stale contents are never looked at.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < DIVIDER_DELAY; i++) begin
        trk_valid_q[i] <= 1'b0;
        trk_port_q[i]  <= PORT_A;
        trk_tag_q[i]   <= '0;
        trk_zero_q[i]  <= 1'b0;
      end
    end else if (iEnable) begin
      trk_valid_q[0] <= issue_valid_q;
      trk_port_q[0]  <= issue_port_q;
      trk_tag_q[0]   <= issue_tag_q;
      trk_zero_q[0]  <= issue_zero_q;
      for (int i = 1; i < DIVIDER_DELAY; i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_port_q[i]  <= trk_port_q[i-1];
        trk_tag_q[i]   <= trk_tag_q[i-1];
        trk_zero_q[i]  <= trk_zero_q[i-1];
      end
    end
  end

  fp_divider #(
    .DELAY (DIVIDER_DELAY)
  ) u_fp_divider (
    .clk_i    (iClock),
    .clk_en_i (iEnable),
    .a_i      (issue_num_q),
    .b_i      (issue_den_q),
    .q_o      (div_result)
  );

  // Gating the strobe with iEnable keeps a held result visible for exactly
  // one enabled cycle even when the enable drops right after it lands.
  assign bus.oA_Ready     = ready_a;
  assign bus.oB_Ready     = ready_b;
  assign bus.oA_Valid     = a_valid_q & iEnable & ~iReset;
  assign bus.oB_Valid     = b_valid_q & iEnable & ~iReset;
  assign bus.ofA_Quotient = a_quot_q;
  assign bus.ofB_Quotient = b_quot_q;
  assign bus.oA_Tag       = a_tag_q;
  assign bus.oB_Tag       = b_tag_q;
  assign bus.oA_DivZero   = a_dz_q;
  assign bus.oB_DivZero   = b_dz_q;

endmodule

// File: tb/tb_fp_divider_scheduler.sv
module tb_fp_divider_scheduler;
  import encoder_fp_pkg::*;

  localparam int D  = 14;
  localparam int TW = 4;

  typedef struct packed {
    logic [31:0]   num;
    logic [31:0]   den;
    logic [31:0]   q;
    logic [TW-1:0] tag;
  } vec_t;

  typedef struct packed {
    logic [31:0]   q;
    logic [TW-1:0] tag;
    logic          dz;
    int            due;
  } exp_t;

  typedef struct packed {
    logic [31:0]   q;
    logic [TW-1:0] tag;
    logic          dz;
    int            cyc;
  } res_t;

  // ---------------- clock / reset ----------------
  logic iClock  = 1'b0;
  logic iReset  = 1'b1;
  logic iEnable = 1'b1;
  always #5 iClock = ~iClock;

  fp_divider_scheduler_if #(.TAG_WIDTH(TW)) bus ();

  fp_divider_scheduler #(
    .DIVIDER_DELAY (D),
    .TAG_WIDTH     (TW)
  ) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iEnable (iEnable),
    .bus     (bus)
  );

  // ---------------- bench state ----------------
  vec_t a_stim[$], b_stim[$];
  exp_t exp_a_q[$], exp_b_q[$];
  res_t a_res[$], b_res[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  logic m_last = 1'b1;
  logic started = 1'b0;
  res_t a_hold = '0;
  res_t b_hold = '0;
  logic m_ea, m_eb, ev;
  exp_t ne;
  logic acc_a, acc_b, both_seen, a_not_ready;
  int   a_first_acc = -1;
  int   a_run = 0;
  int   a_maxrun = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- model + compare ----------------
  // Each accepted request is due at enabled-edge count (accept count + D + 1);
  // it must be visible exactly while that count holds and iEnable is high.
  always @(negedge iClock) begin
    m_ea = iEnable && !iReset && bus.iA_Valid && (!bus.iB_Valid || m_last);
    m_eb = iEnable && !iReset && bus.iB_Valid && !m_ea;
    if (started) begin
      check("a_ready", bus.oA_Ready, m_ea);
      check("b_ready", bus.oB_Ready, m_eb);
      while (exp_a_q.size() > 0 && exp_a_q[0].due < en_cnt) begin
        check("a_missing", 1, 0);
        void'(exp_a_q.pop_front());
      end
      while (exp_b_q.size() > 0 && exp_b_q[0].due < en_cnt) begin
        check("b_missing", 1, 0);
        void'(exp_b_q.pop_front());
      end
      ev = iEnable && !iReset;
      if (exp_a_q.size() > 0 && exp_a_q[0].due == en_cnt) begin
        check("a_valid", bus.oA_Valid, ev);
        check("a_quot", bus.ofA_Quotient, exp_a_q[0].q);
        check("a_tag", bus.oA_Tag, exp_a_q[0].tag);
        check("a_dz", bus.oA_DivZero, exp_a_q[0].dz);
        if (ev) begin
          a_hold = '{q: exp_a_q[0].q, tag: exp_a_q[0].tag, dz: exp_a_q[0].dz, cyc: 0};
          void'(exp_a_q.pop_front());
        end
      end else begin
        check("a_valid", bus.oA_Valid, 0);
        check("a_quot_hold", bus.ofA_Quotient, a_hold.q);
        check("a_tag_hold", bus.oA_Tag, a_hold.tag);
        check("a_dz_hold", bus.oA_DivZero, a_hold.dz);
      end
      if (exp_b_q.size() > 0 && exp_b_q[0].due == en_cnt) begin
        check("b_valid", bus.oB_Valid, ev);
        check("b_quot", bus.ofB_Quotient, exp_b_q[0].q);
        check("b_tag", bus.oB_Tag, exp_b_q[0].tag);
        check("b_dz", bus.oB_DivZero, exp_b_q[0].dz);
        if (ev) begin
          b_hold = '{q: exp_b_q[0].q, tag: exp_b_q[0].tag, dz: exp_b_q[0].dz, cyc: 0};
          void'(exp_b_q.pop_front());
        end
      end else begin
        check("b_valid", bus.oB_Valid, 0);
        check("b_quot_hold", bus.ofB_Quotient, b_hold.q);
        check("b_tag_hold", bus.oB_Tag, b_hold.tag);
        check("b_dz_hold", bus.oB_DivZero, b_hold.dz);
      end
      if (bus.oA_Valid) begin
        a_res.push_back('{q: bus.ofA_Quotient, tag: bus.oA_Tag, dz: bus.oA_DivZero, cyc: cyc});
        a_run++;
        if (a_run > a_maxrun) a_maxrun = a_run;
      end else begin
        a_run = 0;
      end
      if (bus.oB_Valid)
        b_res.push_back('{q: bus.ofB_Quotient, tag: bus.oB_Tag, dz: bus.oB_DivZero, cyc: cyc});
    end
    // Predict the coming edge.
    if (iReset) begin
      exp_a_q.delete();
      exp_b_q.delete();
      m_last  = 1'b1;
      a_hold  = '0;
      b_hold  = '0;
      started = 1'b1;
    end else if (iEnable) begin
      en_cnt++;
      if (m_ea) begin
        ne = '{q: a_stim[0].q, tag: a_stim[0].tag, dz: (a_stim[0].den[30:0] == 31'd0), due: en_cnt + D + 1};
        exp_a_q.push_back(ne);
        m_last = 1'b0;
      end
      if (m_eb) begin
        ne = '{q: b_stim[0].q, tag: b_stim[0].tag, dz: (b_stim[0].den[30:0] == 31'd0), due: en_cnt + D + 1};
        exp_b_q.push_back(ne);
        m_last = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic present();
    if (a_stim.size() > 0) begin
      bus.iA_Valid = 1'b1;
      bus.ifA_Num  = a_stim[0].num;
      bus.ifA_Den  = a_stim[0].den;
      bus.iA_Tag   = a_stim[0].tag;
    end else begin
      bus.iA_Valid = 1'b0;
      bus.ifA_Num  = '0;
      bus.ifA_Den  = '0;
      bus.iA_Tag   = '0;
    end
    if (b_stim.size() > 0) begin
      bus.iB_Valid = 1'b1;
      bus.ifB_Num  = b_stim[0].num;
      bus.ifB_Den  = b_stim[0].den;
      bus.iB_Tag   = b_stim[0].tag;
    end else begin
      bus.iB_Valid = 1'b0;
      bus.ifB_Num  = '0;
      bus.ifB_Den  = '0;
      bus.iB_Tag   = '0;
    end
  endtask

  task automatic step(input logic en, input logic rst);
    iEnable = en;
    iReset  = rst;
    present();
    @(negedge iClock);
    acc_a = bus.iA_Valid && bus.oA_Ready;
    acc_b = bus.iB_Valid && bus.oB_Ready;
    if (bus.oA_Ready && bus.oB_Ready) both_seen = 1'b1;
    if (!bus.oA_Ready) a_not_ready = 1'b1;
    @(posedge iClock);
    #1;
    if (acc_a) begin
      if (a_first_acc < 0) a_first_acc = cyc;
      grant_log.push_back(0);
      void'(a_stim.pop_front());
    end
    if (acc_b) begin
      grant_log.push_back(1);
      void'(b_stim.pop_front());
    end
  endtask

  task automatic push_a(input logic [31:0] num, input logic [31:0] den, input logic [31:0] q, input int tag);
    a_stim.push_back('{num: num, den: den, q: q, tag: tag[TW-1:0]});
  endtask

  task automatic push_b(input logic [31:0] num, input logic [31:0] den, input logic [31:0] q, input int tag);
    b_stim.push_back('{num: num, den: den, q: q, tag: tag[TW-1:0]});
  endtask

  // ---------------- directed tests ----------------
  int na, nb;

  initial begin
    present();
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("rst_a_valid", bus.oA_Valid, 0);
    check("rst_b_valid", bus.oB_Valid, 0);
    check("rst_a_quot", bus.ofA_Quotient, 32'h0);
    check("rst_b_tag", bus.oB_Tag, 0);
    check("rst_b_dz", bus.oB_DivZero, 0);

    // Single A divide: 1.0 / 2.0
    na = a_res.size(); nb = b_res.size(); a_first_acc = -1;
    push_a(32'h3F800000, 32'h40000000, 32'h3F000000, 3);
    repeat (22) step(1'b1, 1'b0);
    check("t1_count", a_res.size(), na + 1);
    if (a_res.size() > na) begin
      check("t1_quot", a_res[na].q, 32'h3F000000);
      check("t1_tag", a_res[na].tag, 3);
      check("t1_latency", a_res[na].cyc - a_first_acc, D + 1);
    end
    check("t1_b_quiet", b_res.size(), nb);

    // Zero denominator on B, then a normal divide
    nb = b_res.size();
    push_b(32'h3F800000, 32'h80000000, 32'h00000000, 7);
    push_b(32'h40800000, 32'h40000000, 32'h40000000, 8);
    repeat (22) step(1'b1, 1'b0);
    check("t2_count", b_res.size(), nb + 2);
    if (b_res.size() > nb + 1) begin
      check("t2_zero_quot", b_res[nb].q, 32'h0);
      check("t2_zero_dz", b_res[nb].dz, 1);
      check("t2_zero_tag", b_res[nb].tag, 7);
      check("t2_next_dz", b_res[nb+1].dz, 0);
      check("t2_next_quot", b_res[nb+1].q, 32'h40000000);
    end

    // Simultaneous streaming
    na = a_res.size(); nb = b_res.size();
    grant_log.delete(); both_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_a(32'h40800000, 32'h40000000, 32'h40000000, 1 + i);
      push_b(32'h41000000, 32'h40800000, 32'h40000000, 9 + i);
    end
    repeat (26) step(1'b1, 1'b0);
    check("t3_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("t3_grant_order", grant_log[i], i % 2);
    check("t3_both_ready", both_seen, 0);
    check("t3_a_count", a_res.size(), na + 4);
    check("t3_b_count", b_res.size(), nb + 4);
    for (int i = 0; i < 4; i++) begin
      if (a_res.size() > na + i) check("t3_a_tag", a_res[na+i].tag, 1 + i);
      if (b_res.size() > nb + i) check("t3_b_tag", b_res[nb+i].tag, 9 + i);
    end

    // Enable gaps: 12 requests of 3.0 / 1.0, enable low for 3 cycles mid-stream
    na = a_res.size(); a_first_acc = -1;
    for (int i = 0; i < 12; i++) push_a(32'h40400000, 32'h3F800000, 32'h40400000, i);
    repeat (5) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);
    check("t4_count", a_res.size(), na + 12);
    for (int i = 0; i < 12; i++)
      if (a_res.size() > na + i) check("t4_tag_order", a_res[na+i].tag, i);
    if (a_res.size() >= na + 12)
      check("t4_last_arrival", a_res[na+11].cyc - a_first_acc, 11 + 3 + D + 1);

    // Reset mid-flight
    na = a_res.size();
    for (int i = 0; i < 5; i++) push_a(32'h40400000, 32'h3F800000, 32'h40400000, 1 + i);
    repeat (7) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0);
    check("t5_no_valid", a_res.size(), na);
    check("t5_a_quot_zero", bus.ofA_Quotient, 32'h0);
    check("t5_a_tag_zero", bus.oA_Tag, 0);
    push_a(32'h40800000, 32'h40000000, 32'h40000000, 6);
    push_b(32'h41000000, 32'h40800000, 32'h40000000, 13);
    nb = b_res.size();
    step(1'b1, 1'b0);
    check("t5_tie_a", acc_a, 1);
    check("t5_tie_b", acc_b, 0);
    repeat (20) step(1'b1, 1'b0);
    check("t5_after_count", a_res.size(), na + 1);
    if (a_res.size() > na) begin
      check("t5_after_quot", a_res[na].q, 32'h40000000);
      check("t5_after_tag", a_res[na].tag, 6);
    end
    check("t5_b_count", b_res.size(), nb + 1);
    if (b_res.size() > nb) check("t5_b_tag", b_res[nb].tag, 13);

    // Full throughput, A only
    na = a_res.size(); a_not_ready = 1'b0; a_maxrun = 0;
    for (int i = 0; i < 20; i++) push_a(32'h40400000, 32'h3F800000, 32'h40400000, i % 16);
    repeat (20) step(1'b1, 1'b0);
    check("t6_ready_always", a_not_ready, 0);
    repeat (20) step(1'b1, 1'b0);
    check("t6_count", a_res.size(), na + 20);
    check("t6_consecutive", a_maxrun, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
